// File: rtl/iir_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : iir_result_packer
// Purpose  : Buffers per-cycle IIR filter results in a small FIFO and
//            serializes each one as three little-endian bytes on a
//            valid/ready byte stream. Results arriving while the FIFO is
//            full and not draining are dropped and flagged by a sticky
//            overflow bit.
// Options  : IIR_PACK_CKSUM_EN - when defined, an XOR checksum byte of all
//            data bytes is appended after every FRAME_LEN results.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active low
//            in_valid   - result strobe
//            in_data    - result word (DATA_W bits)
//            out_valid  - out_byte holds a valid byte (registered)
//            out_ready  - consumer accepts out_byte
//            out_byte   - serialized byte (registered)
//            overflow   - sticky, a result was dropped
//            fifo_level - FIFO occupancy (excludes the result being sent)
// Revision : 1.0 - initial release
// ============================================================================
module iir_result_packer #(
    parameter int DATA_W     = 17,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_LEN  = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_byte,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(FIFO_DEPTH);

    // Elaboration-time parameter sanity checks
    if (DATA_W < 9 || DATA_W > 24) begin : g_bad_data_w
        $error("iir_result_packer: DATA_W must be 9..24");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("iir_result_packer: FIFO_DEPTH must be a power of two >= 2");
    end
    if (FRAME_LEN < 1) begin : g_bad_frame
        $error("iir_result_packer: FRAME_LEN must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2
`ifdef IIR_PACK_CKSUM_EN
        , S_CK
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_W-1:0]      r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_PTR_W-1:0]     r_rptr;
    logic [c_PTR_W:0]       r_level;
    logic                   r_overflow;
    logic [23:8]            r_data;      // upper bytes of the result being sent
    logic [7:0]             r_out_byte;
    logic                   r_out_valid;

    logic                   w_accept;
    logic                   w_nonempty;
    logic [23:0]            w_head;
    logic                   w_pop;
    logic                   w_push;
    logic [7:0]             w_byte_nxt;
    logic                   w_valid_nxt;

`ifdef IIR_PACK_CKSUM_EN
    localparam int                 c_FC_W    = $clog2(FRAME_LEN + 1);
    localparam logic [c_FC_W-1:0]  c_FC_LAST = c_FC_W'(FRAME_LEN - 1);
    logic [7:0]             r_cksum;
    logic [c_FC_W-1:0]      r_frame_cnt;
`endif

    assign w_accept   = r_out_valid & out_ready;
    assign w_nonempty = (r_level != '0);
    assign w_head     = 24'(r_mem[r_rptr]);   // zero pad above DATA_W
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_push     = in_valid & ((r_level != c_FULL) | w_pop);

    // Next-state / next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_byte_nxt  = r_out_byte;
        w_valid_nxt = r_out_valid;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_B0;
                    w_byte_nxt  = w_head[7:0];
                    w_valid_nxt = 1'b1;
                end
            end
            S_B0: begin
                if (w_accept) begin
                    w_state_nxt = S_B1;
                    w_byte_nxt  = r_data[15:8];
                end
            end
            S_B1: begin
                if (w_accept) begin
                    w_state_nxt = S_B2;
                    w_byte_nxt  = r_data[23:16];
                end
            end
            S_B2: begin
                if (w_accept) begin
`ifdef IIR_PACK_CKSUM_EN
                    if (r_frame_cnt == c_FC_LAST) begin
                        // Checksum must include the B2 byte leaving now.
                        w_state_nxt = S_CK;
                        w_byte_nxt  = r_cksum ^ r_out_byte;
                    end else
`endif
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_B0;
                        w_byte_nxt  = w_head[7:0];
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_byte_nxt  = 8'h00;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
`ifdef IIR_PACK_CKSUM_EN
            S_CK: begin
                if (w_accept) begin
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_B0;
                        w_byte_nxt  = w_head[7:0];
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_byte_nxt  = 8'h00;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_byte_nxt  = 8'h00;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pointers, level and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_data      <= '0;
            r_out_byte  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_byte  <= w_byte_nxt;
            r_out_valid <= w_valid_nxt;
            if (w_pop) begin
                r_data <= w_head[23:8];
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_PTR_W+1)'(1);
                2'b01:   r_level <= r_level - (c_PTR_W+1)'(1);
                default: r_level <= r_level;
            endcase
            if (in_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef IIR_PACK_CKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cksum     <= 8'h00;
            r_frame_cnt <= '0;
        end else if (w_accept) begin
            case (r_state)
                S_B0, S_B1: r_cksum <= r_cksum ^ r_out_byte;
                S_B2: begin
                    r_cksum     <= r_cksum ^ r_out_byte;
                    r_frame_cnt <= r_frame_cnt + c_FC_W'(1);
                end
                S_CK: begin
                    r_cksum     <= 8'h00;
                    r_frame_cnt <= '0;
                end
                default: ;
            endcase
        end
    end
`endif

    // FIFO storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_byte   = r_out_byte;
    assign overflow   = r_overflow;
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_iir_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_result_packer
// Purpose  : Directed self-checking bench for iir_result_packer: reset
//            values, single-result latency, backpressure, overflow and
//            draining, full-FIFO push with simultaneous pop, asynchronous
//            reset mid-transfer, and (with IIR_PACK_CKSUM_EN) the frame
//            checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir_result_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [16:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        overflow;
    logic [3:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] rx_q [$];

    // Long frame so no checksum byte appears inside any test of this instance.
    iir_result_packer #(
        .DATA_W     (17),
        .FIFO_DEPTH (8),
        .FRAME_LEN  (64)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

`ifdef IIR_PACK_CKSUM_EN
    logic        ck_in_valid;
    logic [16:0] ck_in_data;
    logic        ck_out_valid;
    logic        ck_out_ready;
    logic [7:0]  ck_out_byte;
    logic        ck_overflow;
    logic [3:0]  ck_fifo_level;

    iir_result_packer #(
        .DATA_W     (17),
        .FIFO_DEPTH (8),
        .FRAME_LEN  (2)
    ) u_dut_ck (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (ck_in_valid),
        .in_data    (ck_in_data),
        .out_valid  (ck_out_valid),
        .out_ready  (ck_out_ready),
        .out_byte   (ck_out_byte),
        .overflow   (ck_overflow),
        .fifo_level (ck_fifo_level)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: active edge, then back to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Consume bytes with ready high for a fixed number of cycles.
    task automatic drain(input int n);
        out_ready = 1'b1;
        rx_q.delete();
        for (int i = 0; i < n; i++) begin
            if (out_valid) rx_q.push_back(out_byte);
            tick();
        end
    endtask

    function automatic logic [16:0] val(input int i);
        return 17'h10000 + 17'(i * 'h111);
    endfunction

    function automatic logic [23:0] rx_word(input int r);
        return {rx_q[3*r+2], rx_q[3*r+1], rx_q[3*r]};
    endfunction

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef IIR_PACK_CKSUM_EN
        ck_in_valid  = 1'b0;
        ck_in_data   = '0;
        ck_out_ready = 1'b0;
`endif
        #3;
        // ---------------- reset values ----------------
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_byte",  32'(out_byte),  32'h00);
        check("rst_ovf",   32'(overflow),  32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);

        // ---------------- single result ----------------
        reset_dut();
        in_valid = 1'b1; in_data = 17'h1ABCD; out_ready = 1'b1;
        tick();                               // edge N: push
        in_valid = 1'b0;
        check("t1_level_n",  32'(fifo_level), 32'd1);
        check("t1_valid_n",  32'(out_valid),  32'd0);
        tick();                               // edge N+1: pop
        check("t1_level_n1", 32'(fifo_level), 32'd0);
        check("t1_valid_b0", 32'(out_valid),  32'd1);
        check("t1_b0",       32'(out_byte),   32'hCD);
        tick();
        check("t1_valid_b1", 32'(out_valid),  32'd1);
        check("t1_b1",       32'(out_byte),   32'hAB);
        tick();
        check("t1_valid_b2", 32'(out_valid),  32'd1);
        check("t1_b2",       32'(out_byte),   32'h01);
        tick();
        check("t1_idle",     32'(out_valid),  32'd0);

        // ---------------- backpressure ----------------
        reset_dut();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 17'h00123;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(out_valid), 32'd1);
            check("t2_hold_byte",  32'(out_byte),  32'h23);
            tick();
        end
        out_ready = 1'b1;
        check("t2_b0", 32'(out_byte), 32'h23);
        tick();
        check("t2_b1", 32'(out_byte), 32'h01);
        tick();
        check("t2_b2", 32'(out_byte), 32'h00);
        check("t2_b2_valid", 32'(out_valid), 32'd1);
        tick();
        check("t2_idle", 32'(out_valid), 32'd0);

        // ---------------- overflow and drain ----------------
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = val(i);
            tick();
        end
        in_valid = 1'b0;
        check("t3_level_full", 32'(fifo_level), 32'd8);
        check("t3_ovf_set",    32'(overflow),   32'd1);
        drain(40);
        out_ready = 1'b0;
        check("t3_nbytes", 32'(rx_q.size()), 32'd27);
        if (rx_q.size() >= 27) begin
            for (int r = 0; r < 9; r++) begin
                check("t3_word", 32'(rx_word(r)), 32'(val(r)));
            end
        end
        check("t3_ovf_sticky", 32'(overflow),   32'd1);
        check("t3_level_empty", 32'(fifo_level), 32'd0);

        // ---------------- asynchronous reset while B1 pending ----------------
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = val(i);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();                               // B0 accepted
        out_ready = 1'b0;
        check("t5_pre_b1",  32'(out_byte), 32'(val(0) >> 8) & 32'hFF);
        check("t5_pre_ovf", 32'(overflow), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid),  32'd0);
        check("t5_async_level", 32'(fifo_level), 32'd0);
        check("t5_async_ovf",   32'(overflow),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                if (out_valid) seen++;
                tick();
            end
            check("t5_quiet_after_rst", 32'(seen), 32'd0);
        end

        // ---------------- full FIFO push with same-edge pop ----------------
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = val(i);
            tick();
        end
        in_valid = 1'b0;
        check("t4_level_pre", 32'(fifo_level), 32'd8);
        check("t4_ovf_pre",   32'(overflow),   32'd0);
        out_ready = 1'b1;
        tick();                               // B0 accepted
        tick();                               // B1 accepted, now in B2
        in_valid = 1'b1; in_data = 17'h1F00D;
        tick();                               // B2 accepted, pop and push
        in_valid = 1'b0; out_ready = 1'b0;
        check("t4_level", 32'(fifo_level), 32'd8);
        check("t4_ovf",   32'(overflow),   32'd0);
        check("t4_next_b0", 32'(out_byte), 32'(val(1)) & 32'hFF);
        drain(40);
        out_ready = 1'b0;
        check("t4_nbytes", 32'(rx_q.size()), 32'd27);
        if (rx_q.size() >= 27) begin
            check("t4_first", 32'(rx_word(0)), 32'(val(1)));
            check("t4_last",  32'(rx_word(8)), 32'h1F00D);
        end

`ifdef IIR_PACK_CKSUM_EN
        // ---------------- checksum frames (FRAME_LEN=2) ----------------
        reset_dut();
        begin
            logic [16:0] ck_vals [4];
            logic [7:0]  ck_exp  [14];
            logic [7:0]  ck_rx   [$];
            ck_vals = '{17'h00001, 17'h10100, 17'h000AB, 17'h00C00};
            ck_exp  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01,
                        8'hAB, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'hA7};
            ck_out_ready = 1'b1;
            for (int i = 0; i < 40; i++) begin
                ck_in_valid = (i < 4);
                ck_in_data  = (i < 4) ? ck_vals[i] : 17'h0;
                if (ck_out_valid) ck_rx.push_back(ck_out_byte);
                tick();
            end
            ck_in_valid = 1'b0;
            check("ck_nbytes", 32'(ck_rx.size()), 32'd14);
            if (ck_rx.size() >= 14) begin
                for (int i = 0; i < 14; i++) begin
                    check("ck_byte", 32'(ck_rx[i]), 32'(ck_exp[i]));
                end
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
